// File: rtl/k12a_sram_ctl.sv
// k12a_sram_ctl
//   Bus responder between the K12A CPU memory port and an asynchronous SRAM.
//   One read or write is accepted at a time over a valid/ready handshake.
//   The SRAM strobes are timed in sys_clock cycles and come straight from flops.
//
// Ports
//   sys_clock, reset         clock (rising edge); synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_write, req_addr,     request type (1 = write), address and write data
//   req_wdata
//   resp_valid, resp_rdata   one-cycle completion pulse; read data held until
//                            the next read completes
//   sram_addr, sram_wdata    registered SRAM address and write data
//   sram_data_oe             tristate enable for sram_wdata
//   sram_data_in             SRAM read data
//   sram_ce_n/we_n/oe_n      active-low SRAM strobes
//
// Build option
//   K12A_SRAM_POSTED_WRITE_EN  writes respond in the cycle after acceptance;
//                              DONE then responds for reads only.
module k12a_sram_ctl #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 1,
  parameter int unsigned READ_CYCLES  = 2
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_data_oe,
  input  logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  sram_ce_n,
  output logic                  sram_we_n,
  output logic                  sram_oe_n
);

  localparam int unsigned MAX_WR  = (SETUP_CYCLES > PULSE_CYCLES)
                                  ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                                  : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int unsigned MAX_CYC = (MAX_WR > READ_CYCLES) ? MAX_WR : READ_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  // Counter loads are N-1 so a phase lasts N cycles and ends when cnt_q hits 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    RD,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    resp_q, resp_d;
  logic                    ce_n_q, ce_n_d;
  logic                    we_n_q, we_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    data_oe_q, data_oe_d;
  logic                    accept;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_write) begin
            state_d = W_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = RD;
            cnt_d   = READ_LD;
          end
        end
      end
      W_SETUP: begin
        if (cnt_q == '0) begin
          state_d = W_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_PULSE: begin
        if (cnt_q == '0) begin
          state_d = W_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      W_HOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          rdata_d = sram_data_in;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are decoded from the next state so the flopped outputs line up
    // with the state the FSM is in during the same cycle.
    ce_n_d    = !((state_d == W_SETUP) || (state_d == W_PULSE) ||
                  (state_d == W_HOLD)  || (state_d == RD));
    we_n_d    = (state_d != W_PULSE);
    oe_n_d    = (state_d != RD);
    data_oe_d = (state_d == W_SETUP) || (state_d == W_PULSE) || (state_d == W_HOLD);

`ifdef K12A_SRAM_POSTED_WRITE_EN
    resp_d = (accept && req_write) || ((state_q == RD) && (state_d == DONE));
`else
    resp_d = (state_d == DONE);
`endif
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      ce_n_q    <= ce_n_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign resp_valid   = resp_q;
  assign resp_rdata   = rdata_q;
  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign sram_data_oe = data_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_oe_n    = oe_n_q;

endmodule

// File: tb/tb_k12a_sram_ctl.sv
// Testbench for k12a_sram_ctl. Two instances: dut0 at default timing,
// dut1 with SETUP=2, PULSE=1, HOLD=3, READ=3. Each has its own behavioural
// SRAM and a reference model that predicts every output from the request's
// acceptance cycle and the phase lengths.
module tb_k12a_sram_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef K12A_SRAM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [15:0] req_addr     [2];
  logic [7:0]  req_wdata    [2];
  logic        resp_valid   [2];
  logic [7:0]  resp_rdata   [2];
  logic [15:0] sram_addr    [2];
  logic [7:0]  sram_wdata   [2];
  logic        sram_data_oe [2];
  logic [7:0]  sram_data_in [2];
  logic        sram_ce_n    [2];
  logic        sram_we_n    [2];
  logic        sram_oe_n    [2];

  k12a_sram_ctl #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8),
    .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1), .READ_CYCLES(2)
  ) u_dut0 (
    .sys_clock(clk), .reset(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_data_oe(sram_data_oe[0]),
    .sram_data_in(sram_data_in[0]),
    .sram_ce_n(sram_ce_n[0]), .sram_we_n(sram_we_n[0]), .sram_oe_n(sram_oe_n[0])
  );

  k12a_sram_ctl #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8),
    .SETUP_CYCLES(2), .PULSE_CYCLES(1), .HOLD_CYCLES(3), .READ_CYCLES(3)
  ) u_dut1 (
    .sys_clock(clk), .reset(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_data_oe(sram_data_oe[1]),
    .sram_data_in(sram_data_in[1]),
    .sram_ce_n(sram_ce_n[1]), .sram_we_n(sram_we_n[1]), .sram_oe_n(sram_oe_n[1])
  );

  function automatic int s_of(input int id); return (id == 0) ? 1 : 2; endfunction
  function automatic int p_of(input int id); return (id == 0) ? 2 : 1; endfunction
  function automatic int h_of(input int id); return (id == 0) ? 1 : 3; endfunction
  function automatic int r_of(input int id); return (id == 0) ? 2 : 3; endfunction

  // Behavioural SRAM: unwritten locations read as addr[7:0] ^ 0x7E.
  logic [7:0] sram_mem [2][65536];
  logic [7:0] ref_mem  [2][65536];

  assign sram_data_in[0] = (!sram_ce_n[0] && !sram_oe_n[0]) ? sram_mem[0][sram_addr[0]] : 8'hEE;
  assign sram_data_in[1] = (!sram_ce_n[1] && !sram_oe_n[1]) ? sram_mem[1][sram_addr[1]] : 8'hEE;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (!sram_ce_n[i] && !sram_we_n[i]) sram_mem[i][sram_addr[i]] = sram_wdata[i];
  end

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int errs   = 0;
  int checks = 0;

  function automatic void chk(input string nm, input int id, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", nm, id, pcyc, got, exp);
    end
  endfunction

  // Reference model state: one outstanding request per instance.
  bit          m_busy  [2];
  int          m_t0    [2];
  bit          m_wr    [2];
  logic [15:0] m_addr  [2];
  logic [7:0]  m_wdata [2];
  logic [7:0]  m_rdata [2];

  function automatic void model_step(input int id);
    int k, len, s, p;
    bit act, wlow, rv, rdy;
    s    = s_of(id);
    p    = p_of(id);
    k    = pcyc - m_t0[id];
    len  = m_wr[id] ? (s + p + h_of(id)) : r_of(id);
    act  = 1'b0;
    wlow = 1'b0;
    rv   = 1'b0;
    rdy  = !rst[id];
    if (m_busy[id]) begin
      act  = (k >= 1) && (k <= len);
      wlow = m_wr[id] && (k >= s + 1) && (k <= s + p);
      if (m_wr[id]) rv = POSTED ? (k == 1) : (k == len + 1);
      else          rv = (k == len + 1);
      if (!m_wr[id] && k == len + 1) m_rdata[id] = ref_mem[id][m_addr[id]];
      if (m_wr[id] && k == s + 1)    ref_mem[id][m_addr[id]] = m_wdata[id];
      if (k <= len + 1) rdy = 1'b0;
      if (k >= len + 1) m_busy[id] = 1'b0;
    end
    chk("ce_n",       id, 32'(sram_ce_n[id]),    32'(!act));
    chk("we_n",       id, 32'(sram_we_n[id]),    32'(!wlow));
    chk("oe_n",       id, 32'(sram_oe_n[id]),    32'(!(act && !m_wr[id])));
    chk("data_oe",    id, 32'(sram_data_oe[id]), 32'(act && m_wr[id]));
    chk("resp_valid", id, 32'(resp_valid[id]),   32'(rv));
    chk("resp_rdata", id, 32'(resp_rdata[id]),   32'(m_rdata[id]));
    chk("sram_addr",  id, 32'(sram_addr[id]),    32'(m_addr[id]));
    chk("sram_wdata", id, 32'(sram_wdata[id]),   32'(m_wdata[id]));
    chk("req_ready",  id, 32'(req_ready[id]),    32'(rdy));
    if (rst[id]) begin
      m_busy[id]  = 1'b0;
      m_rdata[id] = '0;
      m_addr[id]  = '0;
      m_wdata[id] = '0;
    end else if (req_valid[id] && rdy) begin
      m_busy[id]  = 1'b1;
      m_t0[id]    = pcyc;
      m_wr[id]    = req_write[id];
      m_addr[id]  = req_addr[id];
      m_wdata[id] = req_wdata[id];
    end
  endfunction

  always @(negedge clk) begin
    if (pcyc >= 1)
      for (int i = 0; i < 2; i++) model_step(i);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present a request and hold it until accepted; returns in cycle 1 of the op.
  task automatic do_req(input int id, input bit w, input logic [15:0] a,
                        input logic [7:0] d, output int tacc);
    int n;
    n    = 0;
    tacc = -1;
    req_valid[id] = 1'b1;
    req_write[id] = w;
    req_addr[id]  = a;
    req_wdata[id] = d;
    do begin
      @(negedge clk);
      if (req_ready[id]) tacc = pcyc;
      n++;
      step();
    end while (tacc < 0 && n < 60);
    chk("accept_in_time", id, 32'(tacc >= 0), 32'd1);
    req_valid[id] = 1'b0;
    req_write[id] = 1'($urandom);
    req_addr[id]  = 16'($urandom);
    req_wdata[id] = 8'($urandom);
  endtask

  // Entered in cycle 1 of an op; reports first resp cycle, ready cycle and we_n-low count.
  task automatic wait_done(input int id, output int rl, output int dl, output int wl);
    rl = -1;
    dl = -1;
    wl = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (resp_valid[id] && rl < 0) rl = k;
      if (!sram_we_n[id]) wl++;
      if (req_ready[id]) begin
        dl = k;
        break;
      end
    end
    chk("done_in_time", id, 32'(dl > 0), 32'd1);
    step();
  endtask

  task automatic run_random(input int id, input int nops);
    int t, rl, dl, wl, sel;
    bit w;
    for (int n = 0; n < nops; n++) begin
      repeat ($urandom_range(0, 2)) step();
      w = 1'($urandom);
      do_req(id, w, 16'h1200 | 16'($urandom_range(0, 15)), 8'($urandom), t);
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        repeat ($urandom_range(0, 6)) step();
        rst[id] = 1'b1;
        step();
        rst[id] = 1'b0;
      end else if (sel < 5) begin
        wait_done(id, rl, dl, wl);
      end
    end
    wait_done(id, rl, dl, wl);
  endtask

  task automatic run_dut0();
    int t1, t2, rl, dl, wl, nresp;
    do_req(0, 1'b1, 16'h1234, 8'hA5, t1);
    wait_done(0, rl, dl, wl);
    chk("wr_resp_lat",  0, 32'(rl), POSTED ? 32'd1 : 32'd5);
    chk("wr_ready_lat", 0, 32'(dl), 32'd6);
    chk("wr_we_low",    0, 32'(wl), 32'd2);

    do_req(0, 1'b0, 16'h0042, 8'h00, t1);
    wait_done(0, rl, dl, wl);
    chk("rd_resp_lat",  0, 32'(rl), 32'd3);
    chk("rd_ready_lat", 0, 32'(dl), 32'd4);
    @(negedge clk);
    chk("rd_data", 0, 32'(resp_rdata[0]), 32'h3C);
    step();

    // Write then read presented back-to-back with valid held high.
    do_req(0, 1'b1, 16'h1203, 8'h5A, t1);
    do_req(0, 1'b0, 16'h1203, 8'h00, t2);
    chk("b2b_gap", 0, 32'(t2 - t1), 32'd6);
    wait_done(0, rl, dl, wl);
    chk("b2b_rd_lat", 0, 32'(rl), 32'd3);
    @(negedge clk);
    chk("b2b_rd_data", 0, 32'(resp_rdata[0]), 32'h5A);
    step();

    // Reset sampled at the end of the first W_PULSE cycle.
    do_req(0, 1'b1, 16'h1205, 8'h11, t1);
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_we_n",  0, 32'(sram_we_n[0]), 32'd1);
    chk("abort_ce_n",  0, 32'(sram_ce_n[0]), 32'd1);
    chk("abort_ready", 0, 32'(req_ready[0]), 32'd1);
    nresp = int'(resp_valid[0]);
    repeat (6) begin
      @(negedge clk);
      nresp += int'(resp_valid[0]);
    end
    chk("abort_no_resp", 0, 32'(nresp), 32'd0);
    step();

    run_random(0, 120);
  endtask

  task automatic run_dut1();
    int t1, rl, dl, wl;
    do_req(1, 1'b1, 16'h1234, 8'hA5, t1);
    wait_done(1, rl, dl, wl);
    chk("wr_resp_lat",  1, 32'(rl), POSTED ? 32'd1 : 32'd7);
    chk("wr_ready_lat", 1, 32'(dl), 32'd8);
    chk("wr_we_low",    1, 32'(wl), 32'd1);

    do_req(1, 1'b0, 16'h1234, 8'h00, t1);
    wait_done(1, rl, dl, wl);
    chk("rd_resp_lat",  1, 32'(rl), 32'd4);
    chk("rd_ready_lat", 1, 32'(dl), 32'd5);
    @(negedge clk);
    chk("rd_data", 1, 32'(resp_rdata[1]), 32'hA5);
    step();

    run_random(1, 120);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]       = 1'b1;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      m_busy[i]    = 1'b0;
      m_t0[i]      = 0;
      m_wr[i]      = 1'b0;
      m_addr[i]    = '0;
      m_wdata[i]   = '0;
      m_rdata[i]   = '0;
      for (int a = 0; a < 65536; a++) begin
        sram_mem[i][a] = 8'(a) ^ 8'h7E;
        ref_mem[i][a]  = 8'(a) ^ 8'h7E;
      end
    end
    repeat (3) @(posedge clk);
    #2;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    fork
      run_dut0();
      run_dut1();
    join
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", pcyc);
    $fatal(1, "watchdog expired");
  end

endmodule
